// File: rtl/ravan_sha_pkg.sv
// Register map, control encodings and FSM state type shared by the
// sha256 bus sequencer.
package ravan_sha_pkg;

  localparam logic [7:0] ADDR_CTRL    = 8'h08;
  localparam logic [7:0] ADDR_STATUS  = 8'h09;
  localparam logic [7:0] ADDR_BLOCK0  = 8'h10;
  localparam logic [7:0] ADDR_DIGEST0 = 8'h20;

  localparam int unsigned CTRL_INIT_BIT    = 0;
  localparam int unsigned CTRL_NEXT_BIT    = 1;
  localparam int unsigned CTRL_MODE_BIT    = 2;
  localparam int unsigned STATUS_VALID_BIT = 1;

  localparam logic [31:0] CTRL_INIT_SHA256 =
    (32'd1 << CTRL_MODE_BIT) | (32'd1 << CTRL_INIT_BIT);
  localparam logic [31:0] CTRL_NEXT_SHA256 =
    (32'd1 << CTRL_MODE_BIT) | (32'd1 << CTRL_NEXT_BIT);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_BLK,
    ST_WR_CTRL,
    ST_GAP,
    ST_POLL,
    ST_RD_DIG,
    ST_OUT,
    ST_ERR
  } seq_state_e;

endpackage

// File: rtl/sha_block_sequencer.sv
// Loads one 512-bit block into the sha256 core, starts init/next, polls for
// digest_valid and returns the 256-bit digest on a valid/ready output.
module sha_block_sequencer
  import ravan_sha_pkg::*;
#(
  parameter int unsigned POLL_LIMIT = 255
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  input  logic         blk_first,
  output logic         dig_valid,
  input  logic         dig_ready,
  output logic [255:0] dig_data,
  output logic         timeout_err,
  output logic         cs,
  output logic         we,
  output logic [7:0]   address,
  output logic [31:0]  write_data,
  input  logic [31:0]  read_data,
  input  logic         sha_error
);

  localparam logic [7:0] POLL_MAX = 8'(POLL_LIMIT);

  seq_state_e   state_q, state_d;
  logic [511:0] blk_q, blk_d;
  logic         first_q, first_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [7:0]   poll_q, poll_d;
  logic [255:0] dig_q, dig_d;
  logic         terr_q, terr_d;
  logic         cs_q, cs_d;
  logic         we_q, we_d;
  logic [7:0]   addr_q, addr_d;
  logic [31:0]  wdata_q, wdata_d;
  logic [31:0]  blk_word;

  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    first_d = first_q;
    cnt_d   = cnt_q;
    poll_d  = poll_q;
    dig_d   = dig_q;
    terr_d  = terr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (blk_valid) begin
          blk_d   = blk_data;
          first_d = blk_first;
          terr_d  = 1'b0;
          cnt_d   = '0;
          state_d = ST_WR_BLK;
        end
      end
      ST_WR_BLK: begin
        if (cnt_q == 4'd15) begin
          cnt_d   = '0;
          state_d = ST_WR_CTRL;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_WR_CTRL: state_d = ST_GAP;
      ST_GAP: begin
        poll_d  = '0;
        state_d = ST_POLL;
      end
      ST_POLL: begin
        if (read_data[STATUS_VALID_BIT]) begin
          cnt_d   = '0;
          state_d = ST_RD_DIG;
        end else begin
          poll_d = poll_q + 8'd1;
          if (poll_q + 8'd1 == POLL_MAX) begin
            terr_d  = 1'b1;
            state_d = ST_ERR;
          end
        end
      end
      ST_RD_DIG: begin
        for (int unsigned i = 0; i < 8; i++) begin
          if (cnt_q[2:0] == i[2:0]) dig_d[255-32*i -: 32] = read_data;
        end
        if (cnt_q == 4'd7) begin
          cnt_d   = '0;
          state_d = ST_OUT;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_OUT:  if (dig_ready) state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // A core error abandons the block; ERR itself still drains to IDLE so a
    // stuck error line cannot wedge the sequencer.
    if (sha_error && state_q != ST_IDLE) begin
      terr_d = 1'b1;
      if (state_q != ST_ERR) begin
        state_d = ST_ERR;
        dig_d   = dig_q;
      end
    end
  end

  // Bus outputs are registered from the next state so they line up with state_q.
  always_comb begin
    blk_word = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (cnt_d == i[3:0]) blk_word = blk_d[511-32*i -: 32];
    end

    cs_d    = 1'b0;
    we_d    = 1'b0;
    addr_d  = '0;
    wdata_d = '0;
    unique case (state_d)
      ST_WR_BLK: begin
        cs_d    = 1'b1;
        we_d    = 1'b1;
        addr_d  = ADDR_BLOCK0 + {4'b0, cnt_d};
        wdata_d = blk_word;
      end
      ST_WR_CTRL: begin
        cs_d    = 1'b1;
        we_d    = 1'b1;
        addr_d  = ADDR_CTRL;
        wdata_d = first_d ? CTRL_INIT_SHA256 : CTRL_NEXT_SHA256;
      end
      ST_POLL: begin
        cs_d   = 1'b1;
        addr_d = ADDR_STATUS;
      end
      ST_RD_DIG: begin
        cs_d   = 1'b1;
        addr_d = ADDR_DIGEST0 + {5'b0, cnt_d[2:0]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      blk_q   <= '0;
      first_q <= 1'b0;
      cnt_q   <= '0;
      poll_q  <= '0;
      dig_q   <= '0;
      terr_q  <= 1'b0;
      cs_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      first_q <= first_d;
      cnt_q   <= cnt_d;
      poll_q  <= poll_d;
      dig_q   <= dig_d;
      terr_q  <= terr_d;
      cs_q    <= cs_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign blk_ready   = (state_q == ST_IDLE);
  assign dig_valid   = (state_q == ST_OUT);
  assign dig_data    = dig_q;
  assign timeout_err = terr_q;
  assign cs          = cs_q;
  assign we          = we_q;
  assign address     = addr_q;
  assign write_data  = wdata_q;

endmodule

// File: tb/tb_sha_block_sequencer.sv
// Bench for sha_block_sequencer: behavioural sha256 register-bus core model,
// table vectors, corner-case sequences and random chained blocks.
`timescale 1ns/1ps
module tb_sha_block_sequencer;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         blk_valid = 1'b0;
  logic         blk_ready;
  logic [511:0] blk_data = '0;
  logic         blk_first = 1'b0;
  logic         dig_valid;
  logic         dig_ready = 1'b0;
  logic [255:0] dig_data;
  logic         timeout_err;
  logic         cs, we;
  logic [7:0]   address;
  logic [31:0]  write_data;
  logic [31:0]  read_data;
  logic         sha_error = 1'b0;

  always #5 clk = ~clk;

  sha_block_sequencer #(.POLL_LIMIT(10)) dut (
    .clk(clk), .reset_n(reset_n),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data), .blk_first(blk_first),
    .dig_valid(dig_valid), .dig_ready(dig_ready), .dig_data(dig_data),
    .timeout_err(timeout_err),
    .cs(cs), .we(we), .address(address), .write_data(write_data),
    .read_data(read_data), .sha_error(sha_error)
  );

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [255:0] IV =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

  function automatic logic [31:0] ror(input logic [31:0] x, input int unsigned s);
    return (x >> s) | (x << (32 - s));
  endfunction

  function automatic logic [255:0] sha_compress(input logic [255:0] h, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    {a, b, c, d, e, f, g, hh} = h;
    for (int i = 0; i < 64; i++) begin
      t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
            h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
  endfunction

  // ---------------- core model: register bus with compute latency ----------
  int           core_lat = 1;
  bit           core_never = 1'b0;
  logic [511:0] m_blk = '0;
  logic [255:0] m_h = '0;
  int           m_busy = 0;
  logic         m_dv = 1'b0;
  logic [31:0]  rd_model;

  always @(posedge clk) begin
    if (cs && we && address[7:4] == 4'h1)
      m_blk[511-32*int'(address[3:0]) -: 32] <= write_data;
    if (cs && we && address == 8'h08) begin
      m_h    <= sha_compress(write_data[0] ? IV : m_h, m_blk);
      m_dv   <= 1'b0;
      m_busy <= core_lat;
    end else if (m_busy > 0) begin
      m_busy <= m_busy - 1;
      if (m_busy == 1 && !core_never) m_dv <= 1'b1;
    end
  end

  always_comb begin
    rd_model = '0;
    if (cs && !we) begin
      if (address == 8'h09) rd_model = {30'd0, m_dv, m_busy == 0};
      else if (address[7:3] == 5'b00100) rd_model = m_h[255-32*int'(address[2:0]) -: 32];
    end
  end
  assign read_data = rd_model;

  // ---------------- bus monitor ---------------------------------------------
  typedef struct { logic [7:0] a; logic [31:0] d; } wr_t;
  wr_t wr_log[$];
  int  n_poll = 0, n_rd = 0, n_inv = 0;
  bit  saw_dv = 1'b0;

  always @(negedge clk) begin
    if (cs && we) wr_log.push_back('{a: address, d: write_data});
    if (cs && !we && address == 8'h09) n_poll++;
    if (cs && !we && address[7:3] == 5'b00100) n_rd++;
    if (!cs && (we || address != 8'h00 || write_data != 32'h0)) n_inv++;
    if (dig_valid) saw_dv = 1'b1;
  end

  // ---------------- checking ------------------------------------------------
  int total = 0, bad = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic accept(input string tag, input logic [511:0] blk, input bit first);
    int n = 0;
    @(negedge clk);
    while (!blk_ready && n < 100) begin @(negedge clk); n++; end
    check({tag, " ready"}, 256'(blk_ready), 256'(1));
    wr_log.delete();
    n_poll = 0; n_rd = 0; saw_dv = 1'b0;
    blk_data = blk; blk_first = first; blk_valid = 1'b1;
    @(negedge clk);
    blk_valid = 1'b0;
    check({tag, " accept"}, 256'({blk_ready, timeout_err}), 256'(2'b00));
  endtask

  task automatic run_block(input string tag, input logic [511:0] blk, input bit first,
                           input int lat, input int hold, input logic [255:0] exp);
    int n;
    bit ok;
    logic [255:0] held;
    logic [39:0]  ctrl_act;
    core_lat = lat; core_never = 1'b0;
    accept(tag, blk, first);
    n = 1;
    while (!dig_valid && n < 300) begin @(negedge clk); n++; end
    check({tag, " latency"}, 256'(n), 256'(27 + lat));
    check({tag, " nwrites"}, 256'(wr_log.size()), 256'(17));
    ok = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i >= wr_log.size() || wr_log[i].a != 8'(8'h10 + i) || wr_log[i].d != blk[511-32*i -: 32])
        ok = 1'b0;
    end
    check({tag, " blkwr"}, 256'(ok), 256'(1));
    ctrl_act = (wr_log.size() > 16) ? {wr_log[16].a, wr_log[16].d} : '1;
    check({tag, " ctrl"}, 256'(ctrl_act), 256'({8'h08, first ? 32'h5 : 32'h6}));
    check({tag, " polls"}, 256'(n_poll), 256'(lat));
    check({tag, " reads"}, 256'(n_rd), 256'(8));
    check({tag, " digest"}, dig_data, exp);
    held = dig_data;
    ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!dig_valid || dig_data !== held || blk_ready) ok = 1'b0;
    end
    if (hold > 0) check({tag, " hold"}, 256'(ok), 256'(1));
    dig_ready = 1'b1;
    @(negedge clk);
    dig_ready = 1'b0;
    check({tag, " release"}, 256'({dig_valid, blk_ready}), 256'(2'b01));
    check({tag, " dig kept"}, dig_data, held);
  endtask

  typedef struct {
    string        tag;
    logic [511:0] blk;
    bit           first;
    int           lat;
    int           hold;
    logic [255:0] exp;
  } vec_t;

  localparam logic [255:0] ABC_DIG =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] TWO_DIG =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  initial begin
    vec_t         vecs [4];
    logic [511:0] abc, two1, two2, rblk;
    logic [255:0] ref_h;
    bit           rfirst;
    int           n;

    abc  = {32'h61626380, 448'd0, 32'h00000018};
    two1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768,
            32'h66676869, 32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d,
            32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h0};
    two2 = {480'd0, 32'h000001c0};

    vecs[0] = '{tag: "abc",    blk: abc,  first: 1'b1, lat: 3, hold: 0,  exp: ABC_DIG};
    vecs[1] = '{tag: "two1",   blk: two1, first: 1'b1, lat: 1, hold: 0,  exp: sha_compress(IV, two1)};
    vecs[2] = '{tag: "two2",   blk: two2, first: 1'b0, lat: 9, hold: 50, exp: TWO_DIG};
    vecs[3] = '{tag: "abc_re", blk: abc,  first: 1'b1, lat: 5, hold: 2,  exp: ABC_DIG};

    repeat (3) @(negedge clk);
    check("reset ctl", 256'({blk_ready, dig_valid, timeout_err, cs, we, address, write_data}),
          256'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0}));
    check("reset dig", dig_data, '0);
    reset_n = 1'b1;

    for (int i = 0; i < 4; i++)
      run_block(vecs[i].tag, vecs[i].blk, vecs[i].first, vecs[i].lat, vecs[i].hold, vecs[i].exp);

    // digest_valid never rises: exactly 10 status reads then timeout
    core_lat = 2; core_never = 1'b1;
    accept("tmo", abc, 1'b1);
    n = 1;
    while (!timeout_err && n < 200) begin @(negedge clk); n++; end
    check("tmo flag", 256'(timeout_err), 256'(1));
    check("tmo polls", 256'(n_poll), 256'(10));
    check("tmo err cycle", 256'({blk_ready, cs}), 256'(2'b00));
    @(negedge clk);
    check("tmo ready back", 256'(blk_ready), 256'(1));
    check("tmo no dv", 256'(saw_dv), 256'(0));
    check("tmo sticky", 256'(timeout_err), 256'(1));

    // reset pulse while block word 7 is on the bus
    accept("rst", abc, 1'b1);
    n = 0;
    while (!(cs && we && address == 8'h17) && n < 100) begin @(negedge clk); n++; end
    check("rst reach w7", 256'({cs, we, address}), 256'({2'b11, 8'h17}));
    #2 reset_n = 1'b0;
    #1;
    check("rst ctl", 256'({blk_ready, dig_valid, timeout_err, cs, we, address, write_data}),
          256'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0}));
    check("rst dig", dig_data, '0);
    @(negedge clk);
    reset_n = 1'b1;
    run_block("post_rst", abc, 1'b1, 4, 0, ABC_DIG);

    // core bus error during polling
    core_lat = 1; core_never = 1'b1;
    accept("serr", abc, 1'b1);
    n = 0;
    while (!(cs && !we && address == 8'h09) && n < 100) begin @(negedge clk); n++; end
    check("serr in poll", 256'({cs, we, address}), 256'({2'b10, 8'h09}));
    sha_error = 1'b1;
    @(negedge clk);
    sha_error = 1'b0;
    check("serr err", 256'({timeout_err, cs, blk_ready}), 256'(3'b100));
    @(negedge clk);
    check("serr idle", 256'(blk_ready), 256'(1));
    repeat (3) @(negedge clk);
    check("serr no dv", 256'(saw_dv), 256'(0));

    // random chained blocks against a transaction-level hash reference
    ref_h = IV;
    for (int i = 0; i < 6; i++) begin
      for (int w = 0; w < 16; w++) rblk[511-32*w -: 32] = $urandom;
      rfirst = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      ref_h  = sha_compress(rfirst ? IV : ref_h, rblk);
      run_block($sformatf("rnd%0d", i), rblk, rfirst, int'($urandom_range(1, 9)),
                int'($urandom_range(0, 3)), ref_h);
    end

    check("bus zero when idle", 256'(n_inv), 256'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sha_block_sequencer.md
# sha_block_sequencer

Register-bus sequencer that sits directly upstream of the `sha256` core and owns its `cs/we/address/write_data/read_data` port. It accepts one 512-bit message block per valid/ready handshake and writes it into the core's block registers. It then issues `init` or `next` in SHA-256 mode, polls status until the digest is valid, reads back the 256-bit digest and presents it on a valid/ready output. It replaces ad-hoc combinational driving of the core with a single registered FSM.

## Interface
- `POLL_LIMIT`, default 255: maximum status reads before declaring timeout; range 1–255.
- `clk` in 1: rising-edge clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `blk_valid` in 1: `blk_data` and `blk_first` are valid.
- `blk_ready` out 1: sequencer can accept a block; high only in IDLE.
- `blk_data` in 512: message block; `[511:480]` is word 0.
- `blk_first` in 1: 1 means issue `init` (new message), 0 means issue `next` (chain).
- `dig_valid` out 1: `dig_data` valid; held until accepted.
- `dig_ready` in 1: consumer accepts the digest.
- `dig_data` out 256: digest; `[255:224]` is digest word 0.
- `timeout_err` out 1: sticky; set on poll timeout; cleared on the next block accept.
- `cs` out 1: core chip select.
- `we` out 1: core write enable.
- `address` out 8: core register address.
- `write_data` out 32: core write data.
- `read_data` in 32: core read data; combinational, valid in the same cycle as `cs=1, we=0`.
- `sha_error` in 1: core bus error; OR-ed into `timeout_err`.

## Operation
- Core register map, shared package constants:
  - `ADDR_CTRL=0x08`: bit0 init, bit1 next, bit2 mode (1 = SHA-256).
  - `ADDR_STATUS=0x09`: bit0 ready, bit1 digest_valid.
  - `ADDR_BLOCK0=0x10` through `0x1F`.
  - `ADDR_DIGEST0=0x20` through `0x27`.
- FSM states: IDLE, WR_BLK, WR_CTRL, GAP, POLL, RD_DIG, OUT, ERR.
- IDLE: `blk_ready=1`. On `blk_valid`:
  - latch `blk_data` and `blk_first`;
  - clear `timeout_err`;
  - set word counter to 0;
  - go to WR_BLK.
- WR_BLK: `cs=1`, `we=1`, `address=0x10+cnt`, `write_data` = word `cnt`. Advances 0 to 15, then goes to WR_CTRL.
- WR_CTRL: `cs=1`, `we=1`, `address=0x08`. `write_data` = `0x5` if first, else `0x6`. Then GAP.
- GAP: one idle cycle (`cs=0`) so a stale ready bit is never sampled. Then POLL with poll counter 0.
- POLL: `cs=1`, `we=0`, `address=0x09`.
  - If `read_data[1]` is set: go to RD_DIG with counter 0.
  - Otherwise increment the poll counter. When it reaches `POLL_LIMIT`, set `timeout_err` and go to ERR.
- RD_DIG: `cs=1`, `we=0`, `address=0x20+cnt`. Capture `read_data` into digest word `cnt` in the same cycle. After word 7, go to OUT.
- OUT: `dig_valid=1`. On `dig_ready`, go to IDLE; `dig_data` holds its value.
- ERR: one cycle with `cs=0`, then IDLE. No `dig_valid` is produced.
- `sha_error` high in any non-IDLE state: set `timeout_err`, abandon the block, go to ERR.
- Bus outputs are registered; all are 0 whenever `cs=0`.

## Timing
- Reset values: state IDLE, `blk_ready=1`, `dig_valid=0`, `dig_data=0`, `timeout_err=0`, `cs=0`, `we=0`, `address=0`, `write_data=0`, all counters 0.
- Reset asserted mid-operation: immediate return to reset values; the in-flight block is discarded.
- Latency from accept edge to `dig_valid`: 1 + 16 + 1 + 1 + P + 8 cycles, where P is the number of polls (≥1).
- Minimum per block: 28 cycles plus the core compute time.
- Only one block is in flight; `blk_ready` stays low until OUT is accepted or ERR completes.
- `dig_ready` held high in OUT: handshake completes the first cycle `dig_valid=1`; IDLE follows the next cycle.
- `blk_valid` and `dig_ready` in the same cycle cannot conflict, since they are accepted in different states.

## Structure
- Package `ravan_sha_pkg`: `ADDR_*` constants, ctrl bit positions, state enum, `CTRL_INIT_SHA256=0x5`, `CTRL_NEXT_SHA256=0x6`.
- Single module; no sub-module.
- Word and poll counters are 4 bits and 8 bits respectively.

## Test plan
- Padded "abc" block, `blk_first=1`, with the real `sha256` core: `dig_data` = `ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad`; exactly 16 block writes, then ctrl `0x5`.
- Two-block message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq": first block with `blk_first=1`, second with `blk_first=0` (ctrl `0x6`). Final digest = `248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1`.
- `dig_ready` held low for 50 cycles: `dig_valid` and `dig_data` stable throughout, `blk_ready=0`; accepted on the first high cycle.
- Core model never sets `digest_valid`, `POLL_LIMIT=10`: exactly 10 status reads, then `timeout_err=1`, no `dig_valid`, `blk_ready` returns after 1 cycle; `timeout_err` clears on the next accept.
- `reset_n` pulsed low during WR_BLK word 7: all outputs at reset values immediately; the next block completes correctly ("abc" digest).
- `sha_error` forced high during POLL: `timeout_err=1`, ERR, then IDLE, and no digest produced.
